hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS core.
- Drives the PC write enable, the IF/ID write/flush controls and the ID/EX bubble insert.
- Resolves four conditions: load-use hazards, taken branches/jumps resolved in ID, instruction-memory wait states, and multi-cycle multiply/divide (MDU) occupancy.
- Also keeps a stall-cycle performance counter.

---
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage MIPS core.
// It resolves load-use hazards, taken branches/jumps resolved in ID,
// instruction-memory wait states and multiply/divide unit occupancy.
// It drives the PC, IF/ID and ID/EX controls and counts cycles in which the
// PC is not written.
module hazard_ctrl #(
    parameter int MDU_LATENCY = 32,  // cycles the MDU stays busy after a start pulse (>= 1)
    parameter int CNT_W       = 6,   // countdown width, 2^CNT_W > MDU_LATENCY
    parameter int PERF_W      = 32   // stall-cycle counter width
) (
    input  logic              clock,
    input  logic              reset,          // asynchronous, active-low
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rt,
    input  logic              id_is_mdu,
    input  logic              id_reads_hilo,
    input  logic              branch_taken_id,
    input  logic              imem_ready,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              mdu_start,
    output logic              mdu_busy,
    output logic [PERF_W-1:0] stall_cycles
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [CNT_W-1:0]  mdu_cnt_reg;
    logic [CNT_W-1:0]  mdu_cnt_next;
    logic [PERF_W-1:0] stall_cnt_reg;

    // Source operands of the ID instruction: index 0 is rs, index 1 is rt.
    logic [4:0] src_reg_num [2];
    logic [1:0] src_used;
    logic [1:0] src_hit;
    logic       lu;
    logic       ms;
    logic       hold;

    assign src_reg_num[0] = id_rs;
    assign src_reg_num[1] = id_rt;
    assign src_used       = {id_uses_rt, id_uses_rs};

    // Each used source register is compared against the load destination.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src_match
            assign src_hit[gi] = src_used[gi] && (src_reg_num[gi] == ex_rt);
        end
    endgenerate

    // Loads targeting $zero never create a dependency.
    assign lu   = ex_mem_read && (ex_rt != 5'd0) && (|src_hit);
    assign ms   = (state_reg == MDU_BUSY) && (id_reads_hilo || id_is_mdu);
    assign hold = lu || ms;

    // Next-state and control outputs; everything is forced low while reset is held.
    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mdu_start    = 1'b0;
        mdu_busy     = (state_reg == MDU_BUSY);
        state_next   = state_reg;
        mdu_cnt_next = mdu_cnt_reg;

        if (reset) begin
            if (hold) begin
                // Freeze PC and IF/ID, push a bubble into EX.
                id_ex_flush = 1'b1;
            end else if (branch_taken_id) begin
                // Redirect wins over a pending fetch, which is simply dropped.
                pc_write    = 1'b1;
                if_id_write = 1'b1;
                if_id_flush = 1'b1;
            end else if (!imem_ready) begin
                // ID moves on, a NOP enters ID, the PC waits for memory.
                if_id_write = 1'b1;
                if_id_flush = 1'b1;
            end else begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
            end

            case (state_reg)
                RUN: begin
                    // The MDU op leaves ID unless blocked by a load-use stall.
                    if (id_is_mdu && !lu) begin
                        mdu_start    = 1'b1;
                        state_next   = MDU_BUSY;
                        mdu_cnt_next = CNT_W'(MDU_LATENCY);
                    end
                end
                MDU_BUSY: begin
                    if (mdu_cnt_reg <= CNT_W'(1)) begin
                        state_next   = RUN;
                        mdu_cnt_next = '0;
                    end else begin
                        mdu_cnt_next = mdu_cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_next   = RUN;
                    mdu_cnt_next = '0;
                end
            endcase
        end
    end

    // State, MDU countdown and stall-cycle counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= RUN;
            mdu_cnt_reg   <= '0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            mdu_cnt_reg <= mdu_cnt_next;
            if (!pc_write) begin
                stall_cnt_reg <= stall_cnt_reg + PERF_W'(1);
            end
        end
    end

    assign stall_cycles = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector bench for hazard_ctrl with MDU_LATENCY=4.
// Inputs change 1 time unit after the rising edge; combinational outputs are
// sampled 4 units after the edge and the stall counter just after the next edge.
module tb_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rs, id_uses_rt, ex_mem_read;
    logic        id_is_mdu, id_reads_hilo, branch_taken_id, imem_ready;
    logic        pc_write, if_id_write, if_id_flush, id_ex_flush;
    logic        mdu_start, mdu_busy;
    logic [31:0] stall_cycles;

    int          n_checks  = 0;
    int          n_errors  = 0;
    logic [31:0] exp_stall = 0;

    hazard_ctrl #(
        .MDU_LATENCY(4),
        .CNT_W      (6),
        .PERF_W     (32)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rs     (id_uses_rs),
        .id_uses_rt     (id_uses_rt),
        .ex_mem_read    (ex_mem_read),
        .ex_rt          (ex_rt),
        .id_is_mdu      (id_is_mdu),
        .id_reads_hilo  (id_reads_hilo),
        .branch_taken_id(branch_taken_id),
        .imem_ready     (imem_ready),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .mdu_start      (mdu_start),
        .mdu_busy       (mdu_busy),
        .stall_cycles   (stall_cycles)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        id_is_mdu = 1'b0; id_reads_hilo = 1'b0;
        branch_taken_id = 1'b0; imem_ready = 1'b1;
    endtask

    task automatic set_lu(input logic [4:0] r);
        ex_mem_read = 1'b1; ex_rt = r; id_rs = r; id_uses_rs = 1'b1;
    endtask

    // One cycle with the current inputs: check outputs mid-cycle, advance, check counter.
    // exp_ctrl = {pc_write, if_id_write, if_id_flush, id_ex_flush}.
    task automatic cyc_check(input string tag, input logic [3:0] exp_ctrl,
                             input logic exp_start, input logic exp_busy);
        #3;
        check({tag, " ctrl"}, 32'({pc_write, if_id_write, if_id_flush, id_ex_flush}), 32'(exp_ctrl));
        check({tag, " mdu_start"}, 32'(mdu_start), 32'(exp_start));
        check({tag, " mdu_busy"}, 32'(mdu_busy), 32'(exp_busy));
        if (!exp_ctrl[3]) exp_stall++;
        @(posedge clock); #1;
        check({tag, " stall_cycles"}, stall_cycles, exp_stall);
        $display("cycle %-14s ctrl=%b%b%b%b start=%b busy=%b stalls=%0d", tag,
                 pc_write, if_id_write, if_id_flush, id_ex_flush, mdu_start, mdu_busy, stall_cycles);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ctrl"}, 32'({pc_write, if_id_write, if_id_flush, id_ex_flush}), 32'd0);
        check({tag, " mdu_start"}, 32'(mdu_start), 32'd0);
        check({tag, " mdu_busy"}, 32'(mdu_busy), 32'd0);
        check({tag, " stall_cycles"}, stall_cycles, 32'd0);
        $display("reset %-14s ctrl=%b%b%b%b busy=%b stalls=%0d", tag,
                 pc_write, if_id_write, if_id_flush, id_ex_flush, mdu_busy, stall_cycles);
    endtask

    initial begin
        // Reset with arbitrary (hazardous) inputs.
        set_idle();
        set_lu(5'd9);
        id_is_mdu = 1'b1; branch_taken_id = 1'b1; imem_ready = 1'b0;
        #2 check_all_zero("rst_a");
        @(posedge clock); #1;
        check_all_zero("rst_b");
        #5;
        set_idle();
        reset = 1'b1;
        @(posedge clock); #1;

        cyc_check("run", 4'b1100, 1'b0, 1'b0);

        // Load-use hazards.
        set_lu(5'd5);
        cyc_check("lu_rs", 4'b0001, 1'b0, 1'b0);
        set_idle(); set_lu(5'd0);
        cyc_check("lu_zero", 4'b1100, 1'b0, 1'b0);
        set_idle(); set_lu(5'd5); id_uses_rs = 1'b0; id_uses_rt = 1'b1; id_rt = 5'd3;
        cyc_check("lu_unused", 4'b1100, 1'b0, 1'b0);
        id_rt = 5'd5;
        cyc_check("lu_rt", 4'b0001, 1'b0, 1'b0);

        // MDU issue followed by HI/LO readers.
        set_idle(); id_is_mdu = 1'b1;
        cyc_check("mdu_issue", 4'b1100, 1'b1, 1'b0);
        set_idle(); id_reads_hilo = 1'b1;
        for (int i = 1; i <= 4; i++) cyc_check($sformatf("hilo_wait%0d", i), 4'b0001, 1'b0, 1'b1);
        cyc_check("hilo_go", 4'b1100, 1'b0, 1'b0);

        // Back-to-back MDU ops: the second waits for the first to finish.
        set_idle(); id_is_mdu = 1'b1;
        cyc_check("mdu_a", 4'b1100, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) cyc_check($sformatf("mdu_b_wait%0d", i), 4'b0001, 1'b0, 1'b1);
        cyc_check("mdu_b", 4'b1100, 1'b1, 1'b0);
        set_idle();
        cyc_check("busy_idle", 4'b1100, 1'b0, 1'b1);

        // Reset in the second busy cycle.
        reset = 1'b0;
        #1 check_all_zero("rst_mid_a");
        @(posedge clock); #1;
        check_all_zero("rst_mid_b");
        reset = 1'b1;
        exp_stall = 0;
        @(posedge clock); #1;
        id_reads_hilo = 1'b1;
        cyc_check("post_rst_hilo", 4'b1100, 1'b0, 1'b0);

        // MDU issue blocked by load-use, then issued alongside a branch with imem not ready.
        set_idle(); set_lu(5'd7); id_is_mdu = 1'b1;
        cyc_check("mdu_lu", 4'b0001, 1'b0, 1'b0);
        set_idle(); id_is_mdu = 1'b1; branch_taken_id = 1'b1; imem_ready = 1'b0;
        cyc_check("mdu_branch", 4'b1110, 1'b1, 1'b0);
        set_idle();
        for (int i = 1; i <= 4; i++) cyc_check($sformatf("drain%0d", i), 4'b1100, 1'b0, 1'b1);

        // Branches.
        branch_taken_id = 1'b1; imem_ready = 1'b0;
        cyc_check("br_nowait", 4'b1110, 1'b0, 1'b0);
        set_lu(5'd12);
        cyc_check("br_lu", 4'b0001, 1'b0, 1'b0);
        set_idle(); branch_taken_id = 1'b1;
        cyc_check("br_ready", 4'b1110, 1'b0, 1'b0);

        // Instruction-memory wait states.
        set_idle(); imem_ready = 1'b0;
        for (int i = 1; i <= 3; i++) cyc_check($sformatf("imem_wait%0d", i), 4'b0110, 1'b0, 1'b0);
        set_idle();
        cyc_check("imem_ok", 4'b1100, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #20000;
        n_errors++;
        $display("FAIL timeout: got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
